// File: rtl/shift_univ_pkg.sv
// Shared encodings for the universal shift register: shift modes, directions
// and the controller's state type.
package shift_univ_pkg;

    localparam logic [1:0] MODE_LOG = 2'b00;
    localparam logic [1:0] MODE_ARI = 2'b01;
    localparam logic [1:0] MODE_ROT = 2'b10;

    localparam logic DIR_R = 1'b0;
    localparam logic DIR_L = 1'b1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/shift_univ_step.sv
// One-position shift of a WIDTH-bit word; returns the new word and the ejected bit.
// Rotate support is present only when SHIFT_REG_UNIV_ROTATE_EN is defined.
module shift_univ_step
    import shift_univ_pkg::*;
#(
    parameter int WIDTH = 9
) (
    input  logic             dir,
    input  logic [1:0]       mode,
    input  logic             ser_in,
    input  logic [WIDTH-1:0] cur,
    output logic [WIDTH-1:0] next,
    output logic             ejected
);

    logic fill;

    always_comb begin
        ejected = (dir == DIR_L) ? cur[WIDTH-1] : cur[0];

        // Fill bit entering at the vacated end; mode 11 falls through to logical.
        fill = ser_in;
        if (mode == MODE_ARI)
            fill = (dir == DIR_L) ? 1'b0 : cur[WIDTH-1];
`ifdef SHIFT_REG_UNIV_ROTATE_EN
        else if (mode == MODE_ROT)
            fill = ejected;
`endif

        if (dir == DIR_L)
            next = {cur[WIDTH-2:0], fill};
        else
            next = {fill, cur[WIDTH-1:1]};
    end

endmodule

// File: rtl/shift_reg_univ.sv
// Universal shift register: parallel load, single-step shift, and a multi-position
// shift run one bit per cycle with start/busy/done. Rotate mode needs SHIFT_REG_UNIV_ROTATE_EN.
module shift_reg_univ
    import shift_univ_pkg::*;
#(
    parameter int WIDTH = 9,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    input  logic             load,
    input  logic             shift,
    input  logic             start,
    input  logic [CNT_W-1:0] amount,
    input  logic             dir,
    input  logic [1:0]       mode,
    input  logic             ser_in,
    output logic [WIDTH-1:0] out,
    output logic             ser_out,
    output logic             busy,
    output logic             done
);

    state_t             state, state_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic               dir_q, dir_nx;
    logic [1:0]         mode_q, mode_nx;
    logic [WIDTH-1:0]   out_nx;
    logic               ser_nx, done_nx;

    logic               step_dir;
    logic [1:0]         step_mode;
    logic [WIDTH-1:0]   step_next;
    logic               step_ej;

    // Idle single shifts use the live controls; a run uses the ones latched at start.
    assign step_dir  = (state == S_RUN) ? dir_q  : dir;
    assign step_mode = (state == S_RUN) ? mode_q : mode;

    shift_univ_step #(.WIDTH(WIDTH)) u_step (
        .dir     (step_dir),
        .mode    (step_mode),
        .ser_in  (ser_in),
        .cur     (out),
        .next    (step_next),
        .ejected (step_ej)
    );

    assign busy = (state == S_RUN);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            out     <= '0;
            ser_out <= 1'b0;
            done    <= 1'b0;
            cnt     <= '0;
            dir_q   <= DIR_R;
            mode_q  <= MODE_LOG;
        end else begin
            state   <= state_nx;
            out     <= out_nx;
            ser_out <= ser_nx;
            done    <= done_nx;
            cnt     <= cnt_nx;
            dir_q   <= dir_nx;
            mode_q  <= mode_nx;
        end
    end

    always_comb begin
        state_nx = state;
        out_nx   = out;
        ser_nx   = ser_out;
        done_nx  = 1'b0;
        cnt_nx   = cnt;
        dir_nx   = dir_q;
        mode_nx  = mode_q;

        case (state)
            S_IDLE: begin
                if (load) begin
                    out_nx = in;
                end else if (start) begin
                    if (amount == '0) begin
                        done_nx = 1'b1;
                    end else begin
                        dir_nx   = dir;
                        mode_nx  = mode;
                        cnt_nx   = amount;
                        state_nx = S_RUN;
                    end
                end else if (shift) begin
                    out_nx = step_next;
                    ser_nx = step_ej;
                end
            end
            S_RUN: begin
                // Load aborts the run silently; start and shift are ignored here.
                if (load) begin
                    out_nx   = in;
                    cnt_nx   = '0;
                    state_nx = S_IDLE;
                end else begin
                    out_nx = step_next;
                    ser_nx = step_ej;
                    cnt_nx = cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state_nx = S_IDLE;
                        done_nx  = 1'b1;
                    end
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_shift_reg_univ.sv
// Directed bench for shift_reg_univ (WIDTH = 9); expected values are hand-computed.
module tb_shift_reg_univ;

    localparam int WIDTH = 9;
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] in;
    logic             load, shift, start, dir, ser_in;
    logic [CNT_W-1:0] amount;
    logic [1:0]       mode;
    logic [WIDTH-1:0] out;
    logic             ser_out, busy, done;

    int checks = 0;
    int errors = 0;

    shift_reg_univ #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in      (in),
        .load    (load),
        .shift   (shift),
        .start   (start),
        .amount  (amount),
        .dir     (dir),
        .mode    (mode),
        .ser_in  (ser_in),
        .out     (out),
        .ser_out (ser_out),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [WIDTH-1:0] rot_exp;

    initial begin
`ifdef SHIFT_REG_UNIV_ROTATE_EN
        rot_exp = 9'h05D;
`else
        rot_exp = 9'h050;
`endif
        rst_n = 1'b0; in = 9'h1FF; load = 1'b1; shift = 1'b0; start = 1'b0;
        amount = '0; dir = 1'b0; mode = 2'b00; ser_in = 1'b0;
        tick(); tick();
        chk("rst_out", out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ser", ser_out, 0);

        rst_n = 1'b1; in = 9'h1A5;
        tick(); load = 1'b0;
        chk("load", out, 9'h1A5);

        // Logical right by 3
        start = 1'b1; amount = 3; dir = 1'b0; mode = 2'b00; ser_in = 1'b0;
        tick(); start = 1'b0;
        chk("lr_busy_e0", busy, 1);
        chk("lr_out_e0", out, 9'h1A5);
        tick();
        chk("lr_out_e1", out, 9'h0D2);
        chk("lr_busy_e1", busy, 1);
        tick();
        chk("lr_busy_e2", busy, 1);
        tick();
        chk("lr_out", out, 9'h034);
        chk("lr_ser", ser_out, 1);
        chk("lr_done", done, 1);
        chk("lr_busy_end", busy, 0);
        tick();
        chk("lr_done_pulse", done, 0);

        // Arithmetic right by 2
        load = 1'b1; in = 9'h1A5; tick(); load = 1'b0;
        start = 1'b1; amount = 2; mode = 2'b01;
        tick(); start = 1'b0;
        tick(); tick();
        chk("ar_out", out, 9'h1E9);
        chk("ar_done", done, 1);

        // Rotate left by 4 (logical fill when rotate is compiled out)
        load = 1'b1; in = 9'h1A5; tick(); load = 1'b0;
        start = 1'b1; amount = 4; dir = 1'b1; mode = 2'b10; ser_in = 1'b0;
        tick(); start = 1'b0;
        tick(); tick(); tick(); tick();
        chk("rl_out", out, rot_exp);
        chk("rl_ser", ser_out, 1);
        chk("rl_done", done, 1);

        // Zero-amount start
        start = 1'b1; amount = 0;
        tick(); start = 1'b0;
        chk("z_done", done, 1);
        chk("z_busy", busy, 0);
        chk("z_out", out, rot_exp);
        tick();
        chk("z_done_pulse", done, 0);

        // Idle single shift, arithmetic right
        load = 1'b1; in = 9'h1A5; tick(); load = 1'b0;
        shift = 1'b1; dir = 1'b0; mode = 2'b01;
        tick(); shift = 1'b0;
        chk("sh_out", out, 9'h1D2);
        chk("sh_ser", ser_out, 1);

        // Shift and live dir/mode changes ignored during RUN; ser_in sampled live
        load = 1'b1; in = 9'h1A5; tick(); load = 1'b0;
        start = 1'b1; amount = 2; dir = 1'b0; mode = 2'b00; ser_in = 1'b1;
        tick(); start = 1'b0;
        shift = 1'b1; dir = 1'b1; mode = 2'b01;
        tick();
        chk("run_out_e1", out, 9'h1D2);
        ser_in = 1'b0;
        tick(); shift = 1'b0;
        chk("run_out", out, 9'h0E9);
        chk("run_ser", ser_out, 0);
        chk("run_done", done, 1);

        // Load aborts an amount-5 run during its second step
        load = 1'b1; in = 9'h1A5; tick(); load = 1'b0;
        start = 1'b1; amount = 5; dir = 1'b0; mode = 2'b00; ser_in = 1'b0;
        tick(); start = 1'b0;
        tick();
        load = 1'b1; in = 9'h0F0;
        tick(); load = 1'b0;
        chk("ab_out", out, 9'h0F0);
        chk("ab_busy", busy, 0);
        chk("ab_done", done, 0);
        tick();
        chk("ab_done_late", done, 0);
        chk("ab_out_hold", out, 9'h0F0);

        // Start during the done cycle chains a new operation
        load = 1'b1; in = 9'h1A5; tick(); load = 1'b0;
        start = 1'b1; amount = 1;
        tick(); start = 1'b0;
        tick();
        chk("bb_done1", done, 1);
        chk("bb_out1", out, 9'h0D2);
        start = 1'b1; amount = 2;
        tick(); start = 1'b0;
        chk("bb_busy2", busy, 1);
        chk("bb_done_clr", done, 0);
        tick(); tick();
        chk("bb_out2", out, 9'h034);
        chk("bb_done2", done, 1);

        // Reset mid-run
        start = 1'b1; amount = 5;
        tick(); start = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        chk("mr_out", out, 0);
        chk("mr_busy", busy, 0);
        chk("mr_done", done, 0);
        chk("mr_ser", ser_out, 0);
        rst_n = 1'b1;
        tick();
        chk("mr_done_after", done, 0);
        chk("mr_busy_after", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
